instr_fetcher: RTL and testbench
================================

# instr_fetcher

Instruction fetch stage with a direct-mapped, one-word-per-line instruction cache. It sits between the memory controller, whose IF request/response port it drives, and the instruction queue, which it feeds. It keeps the fetch PC, serves cache hits at one instruction per cycle, and turns misses into single-word memory requests. The commit/branch logic redirects it through the shared clear/flush signals.

## Interface
- `ICACHE_IDX_W`, default 6: index width; the cache has 2^`ICACHE_IDX_W` lines of 32-bit instructions each.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rdy` in 1: global ready. When low, all state is frozen and both pulse outputs are driven 0.
- `clear_flag_in` in 1: flush/redirect request.
- `clear_pc_in` in 32: new fetch PC, valid while `clear_flag_in` is high.
- `mc_fetch_enable_out` out 1: one-cycle request pulse to the memory controller.
- `mc_addr_out` out 32: fetch address. Held stable from the request pulse until the response arrives.
- `mc_result_enable_in` in 1: one-cycle response strobe from the memory controller.
- `mc_data_in` in 32: fetched word, valid with `mc_result_enable_in`.
- `iq_full_in` in 1: instruction queue cannot accept an instruction in the next cycle.
- `iq_instr_enable_out` out 1: one-cycle strobe; the instruction and its PC are valid.
- `iq_instr_out` out 32: instruction word.
- `iq_pc_out` out 32: PC of `iq_instr_out`.

## Operation
- **Address split:** index = `pc[ICACHE_IDX_W+1:2]`; tag = `pc[31:ICACHE_IDX_W+2]`. PCs are word-aligned and `pc[1:0]` is ignored.
- **Line state:** each line has a valid bit, a tag and a 32-bit data word.
  - Valid bits clear only on `rst`.
  - `clear_flag_in` does not invalidate the cache.
- **FSM states:** IDLE and WAIT_MEM.
- **IDLE, `iq_full_in` = 0, hit:** emit the cached word with `iq_pc_out = pc`; then `pc <= pc + 4`.
- **IDLE, `iq_full_in` = 0, miss:** drive `mc_fetch_enable_out` = 1 for exactly one cycle with `mc_addr_out = pc`; go to WAIT_MEM.
- **IDLE, `iq_full_in` = 1:** no lookup, no request, and pc holds.
- **WAIT_MEM:**
  - No further requests are issued, and `mc_addr_out` holds.
  - On `mc_result_enable_in`, write the line at the index of `mc_addr_out` (valid = 1, tag, data) and return to IDLE.
  - If `iq_full_in` = 0 in that same cycle, also forward the word to the queue (`iq_pc_out = pc`) and set `pc <= pc + 4`.
  - If `iq_full_in` = 1 in that cycle, fill only. The instruction is delivered later as a hit.
- **PC arithmetic:** 32-bit modulo. `0xFFFFFFFC + 4` wraps to `0x00000000`.
- **Clear:** `clear_flag_in` (with `rdy` = 1) has priority over every other event in that cycle:
  - `pc <= clear_pc_in`, state goes to IDLE, and both pulse outputs are 0 in the next cycle.
  - A response arriving in the same cycle as the clear is discarded (no fill, no emit).
  - The memory controller drops its pending IF request on the same clear, so no stale response follows.
- **Reset:** pc = 0, state = IDLE, all valid bits = 0. All outputs reset to 0: `mc_fetch_enable_out`, `mc_addr_out`, `iq_instr_enable_out`, `iq_instr_out`, `iq_pc_out`.

## Timing
- All outputs are registered.
- **Hit:** lookup in cycle t; instruction visible in cycle t+1. Sustained throughput on hits is one instruction per cycle while `iq_full_in` = 0.
- **Miss:** detected in cycle t; `mc_fetch_enable_out` is high in cycle t+1 only.
- **Response:** sampled in cycle r; forwarded instruction visible in cycle r+1; next lookup (pc+4) in cycle r+1.
- **Queue back-pressure:** `iq_full_in` is sampled in the same cycle as the lookup or response. Emission and PC advance happen only when it is 0.
- **Strobes:** `iq_instr_enable_out` is never high on two consecutive cycles for the same PC.
- **`rdy` low:** the cycle is a no-op. PC, state and cache are frozen, and pulse outputs are 0. A response strobe cannot arrive while `rdy` is low, because the memory controller is gated by the same `rdy`.

## Test plan
- **Cold miss then hit:** reset, `iq_full_in` = 0, memory returns `0x00000013` at 0 and `0x00100093` at 4.
  - Required: request at cycle 1 with addr 0.
  - On the response, `iq_pc_out` = 0 and instr = `0x13`.
  - Next request uses addr 4.
- **Hit streaming:** after 0..0xC are cached, redirect to 0.
  - Required: four consecutive strobes with PCs 0, 4, 8, C and no memory request.
- **Back-pressure:**
  - Hold `iq_full_in` = 1 during a hit stream. Required: no strobes and pc frozen; it resumes at the same PC one cycle after release.
  - Hold `iq_full_in` = 1 when a response arrives. Required: line filled, no strobe; the instruction appears as a hit after release.
- **Clear during WAIT_MEM:** pulse `clear_flag_in` with `clear_pc_in` = `0x100`, coincident with `mc_result_enable_in` for addr 8.
  - Required: line 2 is not filled and no strobe occurs.
  - Next request is addr `0x100`.
- **Conflict and wrap:** with `ICACHE_IDX_W` = 6, fetch `0x000` then `0x100` (same index, different tag).
  - Required: the second access misses and refetching `0x000` misses again.
  - Fetch at `0xFFFFFFFC` is followed by pc = `0x00000000`.
- **`rdy` low mid-stream:** drop `rdy` for 3 cycles.
  - Required: no strobes and no state change during those cycles; the stream continues with no PC skipped or duplicated.

Source files
------------

// File: rtl/instr_fetcher_if.sv
// instr_fetcher_if: fetch-stage signals shared with the memory controller, instruction queue and commit logic
interface instr_fetcher_if;
   logic        rdy;
   logic        clear_flag_in;
   logic [31:0] clear_pc_in;
   logic        mc_fetch_enable_out;
   logic [31:0] mc_addr_out;
   logic        mc_result_enable_in;
   logic [31:0] mc_data_in;
   logic        iq_full_in;
   logic        iq_instr_enable_out;
   logic [31:0] iq_instr_out;
   logic [31:0] iq_pc_out;
   modport master (
      input  rdy, clear_flag_in, clear_pc_in, mc_result_enable_in, mc_data_in, iq_full_in,
      output mc_fetch_enable_out, mc_addr_out, iq_instr_enable_out, iq_instr_out, iq_pc_out
   );
   modport slave (
      output rdy, clear_flag_in, clear_pc_in, mc_result_enable_in, mc_data_in, iq_full_in,
      input  mc_fetch_enable_out, mc_addr_out, iq_instr_enable_out, iq_instr_out, iq_pc_out
   );
endinterface

// File: rtl/instr_fetcher.sv
// instr_fetcher: fetch PC with a direct-mapped one-word-per-line icache and single-word miss requests
module instr_fetcher #(
   parameter int ICACHE_IDX_W = 6
) (
   input logic             clk,
   input logic             rst,
   instr_fetcher_if.master bus
);
   localparam int LINES = 1 << ICACHE_IDX_W;
   localparam int TAG_W = 30 - ICACHE_IDX_W;
   typedef enum logic {IDLE, WAIT_MEM} state_t;
   state_t                  r_state;
   logic [31:0]             r_pc;
   logic [31:0]             r_mc_addr;
   logic                    r_mc_fetch;
   logic                    r_iq_en;
   logic [31:0]             r_iq_instr;
   logic [31:0]             r_iq_pc;
   logic [LINES-1:0]        r_valid;
   logic [TAG_W-1:0]        r_tag [LINES];
   logic [31:0]             r_data [LINES];
   logic [ICACHE_IDX_W-1:0] w_idx;
   logic [ICACHE_IDX_W-1:0] w_fill_idx;
   logic                    w_hit;
   assign w_idx      = r_pc[ICACHE_IDX_W+1:2];
   assign w_fill_idx = r_mc_addr[ICACHE_IDX_W+1:2];
   assign w_hit      = r_valid[w_idx] && r_tag[w_idx] == r_pc[31:ICACHE_IDX_W+2];
   // a clear wins over lookup and fill; pulses default low, including while rdy is low
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_pc       <= '0;
         r_mc_addr  <= '0;
         r_mc_fetch <= 1'b0;
         r_iq_en    <= 1'b0;
         r_iq_instr <= '0;
         r_iq_pc    <= '0;
         r_valid    <= '0;
      end else begin
         r_mc_fetch <= 1'b0;
         r_iq_en    <= 1'b0;
         if (bus.rdy && bus.clear_flag_in) begin
            r_pc    <= bus.clear_pc_in;
            r_state <= IDLE;
         end else if (bus.rdy && r_state == IDLE && !bus.iq_full_in) begin
            if (w_hit) begin
               r_iq_en    <= 1'b1;
               r_iq_instr <= r_data[w_idx];
               r_iq_pc    <= r_pc;
               r_pc       <= r_pc + 32'd4;
            end else begin
               r_mc_fetch <= 1'b1;
               r_mc_addr  <= r_pc;
               r_state    <= WAIT_MEM;
            end
         end else if (bus.rdy && r_state == WAIT_MEM && bus.mc_result_enable_in) begin
            r_valid[w_fill_idx] <= 1'b1;
            r_tag[w_fill_idx]   <= r_mc_addr[31:ICACHE_IDX_W+2];
            r_data[w_fill_idx]  <= bus.mc_data_in;
            r_state             <= IDLE;
            if (!bus.iq_full_in) begin
               r_iq_en    <= 1'b1;
               r_iq_instr <= bus.mc_data_in;
               r_iq_pc    <= r_pc;
               r_pc       <= r_pc + 32'd4;
            end
         end
      end
   end
   assign bus.mc_fetch_enable_out = r_mc_fetch;
   assign bus.mc_addr_out         = r_mc_addr;
   assign bus.iq_instr_enable_out = r_iq_en;
   assign bus.iq_instr_out        = r_iq_instr;
   assign bus.iq_pc_out           = r_iq_pc;
endmodule

// File: tb/tb_instr_fetcher.sv
// tb_instr_fetcher: random and directed stimulus, memory responder and scoreboard for instr_fetcher
module tb_instr_fetcher;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   instr_fetcher_if bus();
   instr_fetcher #(.ICACHE_IDX_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));
   int checks = 0;
   int failures = 0;
   logic        n_rdy = 1'b1, n_full = 1'b0, n_clr = 1'b0, n_hold = 1'b0, n_force = 1'b0;
   logic [31:0] n_cpc = '0;
   bit          pend = 1'b0;
   logic [31:0] paddr = '0;
   int          lat = 0;
   logic [31:0] exp_q[$];
   logic [31:0] req_log[$];
   logic [31:0] m_line [64];
   bit          m_v [64];
   bit          outst, p_hit, p_req, p_fwd;
   logic [31:0] oaddr, pc0, last_pc, first_instr;
   int          cyc, first_req_cyc = -1, n_strb = 0, n_req = 0, n_resp = 0;

   function automatic logic [31:0] mem(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      return (w == 32'd4) ? 32'h00100093 : w * 32'h9E3779B1 + 32'h13;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // one cycle: update the memory-controller model from last cycle, then drive this cycle's inputs
   task automatic step();
      @(posedge clk);
      #1;
      if (rst || (bus.rdy && (bus.clear_flag_in || bus.mc_result_enable_in))) pend = 1'b0;
      if (bus.mc_fetch_enable_out) begin
         pend  = 1'b1;
         paddr = bus.mc_addr_out;
         lat   = int'($urandom_range(0, 3));
      end
      bus.rdy                 = n_rdy;
      bus.iq_full_in          = n_full;
      bus.clear_flag_in       = n_clr;
      bus.clear_pc_in         = n_cpc;
      bus.mc_result_enable_in = 1'b0;
      if (pend && n_rdy && (n_force || (!n_hold && lat == 0))) begin
         bus.mc_result_enable_in = 1'b1;
         bus.mc_data_in          = mem(paddr);
      end else if (pend && n_rdy && lat > 0) lat--;
   endtask

   task automatic do_clear(input logic [31:0] pc);
      n_clr = 1'b1;
      n_cpc = pc;
      step();
      n_clr = 1'b0;
   endtask

   task automatic run_until(input int target, input string name);
      for (int i = 0; i < 400 && n_strb < target; i++) step();
      chk(name, 32'(n_strb >= target), 32'd1);
   endtask

   // scoreboard: expected PC stream in exp_q, cache contents as a plain index->address table
   always @(negedge clk) begin
      if (rst) begin
         exp_q = {32'd0, 32'd4, 32'd8, 32'd12};
         outst = 0; p_hit = 0; p_req = 0; p_fwd = 0; cyc = 0;
         foreach (m_v[i]) m_v[i] = 0;
      end else begin
         chk("strobe", 32'(bus.iq_instr_enable_out), 32'(p_hit || p_fwd));
         chk("request", 32'(bus.mc_fetch_enable_out), 32'(p_req));
         if (bus.iq_instr_enable_out) begin
            chk("iq_pc", bus.iq_pc_out, exp_q[0]);
            chk("iq_instr", bus.iq_instr_out, mem(exp_q[0]));
            if (n_strb == 0) first_instr = bus.iq_instr_out;
            n_strb++;
            last_pc = bus.iq_pc_out;
            void'(exp_q.pop_front());
            exp_q.push_back(exp_q[$] + 32'd4);
         end
         if (bus.mc_fetch_enable_out) begin
            chk("req_addr", bus.mc_addr_out, exp_q[0]);
            if (first_req_cyc < 0) first_req_cyc = cyc;
            req_log.push_back(bus.mc_addr_out);
            n_req++;
            outst = 1;
            oaddr = bus.mc_addr_out;
         end else if (outst) chk("addr_hold", bus.mc_addr_out, oaddr);
         p_hit = 0; p_req = 0; p_fwd = 0;
         pc0 = exp_q[0];
         if (bus.rdy) begin
            if (bus.clear_flag_in) begin
               exp_q = {bus.clear_pc_in, bus.clear_pc_in + 32'd4, bus.clear_pc_in + 32'd8, bus.clear_pc_in + 32'd12};
               outst = 0;
            end else if (outst) begin
               if (bus.mc_result_enable_in) begin
                  m_v[oaddr[7:2]]    = 1;
                  m_line[oaddr[7:2]] = oaddr;
                  outst = 0;
                  n_resp++;
                  p_fwd = !bus.iq_full_in;
               end
            end else if (!bus.iq_full_in) begin
               if (m_v[pc0[7:2]] && m_line[pc0[7:2]][31:8] == pc0[31:8]) p_hit = 1;
               else p_req = 1;
            end
         end
         cyc++;
      end
   end

   initial begin
      int s, rq, r;
      bus.rdy = 1'b1; bus.iq_full_in = 1'b0; bus.clear_flag_in = 1'b0; bus.clear_pc_in = '0;
      bus.mc_result_enable_in = 1'b0; bus.mc_data_in = '0;
      repeat (3) step();
      chk("rst_fetch", 32'(bus.mc_fetch_enable_out), 0);
      chk("rst_addr", bus.mc_addr_out, 0);
      chk("rst_iq_en", 32'(bus.iq_instr_enable_out), 0);
      chk("rst_instr", bus.iq_instr_out, 0);
      chk("rst_pc", bus.iq_pc_out, 0);
      rst = 1'b0;
      // cold misses
      run_until(4, "cold_progress");
      chk("first_req_cyc", 32'(first_req_cyc), 1);
      chk("first_instr", first_instr, 32'h13);
      chk("second_req_addr", req_log.size() > 1 ? req_log[1] : 32'hDEAD, 32'd4);
      // hit streaming
      do_clear(32'h0);
      step();
      rq = n_req;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("stream_en", 32'(bus.iq_instr_enable_out), 1);
         chk("stream_pc", bus.iq_pc_out, 32'(i * 4));
         chk("stream_nofetch", 32'(bus.mc_fetch_enable_out), 0);
      end
      chk("stream_noreq", 32'(n_req), 32'(rq));
      // back-pressure on hits
      n_full = 1'b1;
      do_clear(32'h0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_nostrobe", 32'(bus.iq_instr_enable_out), 0);
      end
      n_full = 1'b0;
      step();
      step();
      chk("bp_resume_en", 32'(bus.iq_instr_enable_out), 1);
      chk("bp_resume_pc", bus.iq_pc_out, 32'h0);
      // back-pressure on a response
      do_clear(32'h200);
      step();
      n_full = 1'b1;
      r = n_resp;
      for (int i = 0; i < 50 && n_resp == r; i++) step();
      chk("bp_fill", 32'(n_resp > r), 1);
      s = n_strb;
      repeat (3) step();
      chk("bp_fill_nostrobe", 32'(n_strb), 32'(s));
      rq = n_req;
      n_full = 1'b0;
      step();
      step();
      chk("bp_hit_en", 32'(bus.iq_instr_enable_out), 1);
      chk("bp_hit_pc", bus.iq_pc_out, 32'h200);
      chk("bp_hit_noreq", 32'(n_req), 32'(rq));
      run_until(n_strb + 2, "evict_progress");
      // clear coincident with a response for addr 8
      n_hold = 1'b1;
      do_clear(32'h8);
      step();
      step();
      chk("w_req8_en", 32'(bus.mc_fetch_enable_out), 1);
      chk("w_req8_addr", bus.mc_addr_out, 32'h8);
      step();
      n_clr = 1'b1; n_cpc = 32'h100; n_force = 1'b1;
      step();
      n_clr = 1'b0; n_force = 1'b0; n_hold = 1'b0;
      s = n_strb;
      step();
      chk("clr_quiet_en", 32'(bus.iq_instr_enable_out), 0);
      chk("clr_quiet_fetch", 32'(bus.mc_fetch_enable_out), 0);
      step();
      chk("clr_req_en", 32'(bus.mc_fetch_enable_out), 1);
      chk("clr_req_addr", bus.mc_addr_out, 32'h100);
      chk("clr_no_emit", 32'(n_strb), 32'(s));
      run_until(n_strb + 1, "p100_progress");
      do_clear(32'h8);
      step();
      step();
      chk("line2_unfilled", 32'(bus.mc_fetch_enable_out), 1);
      run_until(n_strb + 1, "p8_progress");
      do_clear(32'h0);
      step();
      step();
      chk("conflict_refetch_en", 32'(bus.mc_fetch_enable_out), 1);
      chk("conflict_refetch_addr", bus.mc_addr_out, 32'h0);
      run_until(n_strb + 1, "p0_progress");
      // wrap
      do_clear(32'hFFFF_FFF8);
      run_until(n_strb + 3, "wrap_progress");
      chk("wrap_pc", last_pc, 32'h0);
      // rdy low mid-stream
      do_clear(32'h0);
      run_until(n_strb + 2, "rdy_pre");
      n_rdy = 1'b0;
      step();
      step();
      chk("rdy_quiet1", 32'(bus.iq_instr_enable_out), 0);
      step();
      chk("rdy_quiet2", 32'(bus.iq_instr_enable_out), 0);
      n_rdy = 1'b1;
      step();
      chk("rdy_quiet3", 32'(bus.iq_instr_enable_out), 0);
      run_until(n_strb + 3, "rdy_post");
      // random traffic
      for (int i = 0; i < 3000; i++) begin
         n_full = ($urandom_range(0, 9) < 3);
         n_rdy  = ($urandom_range(0, 19) != 0);
         n_clr  = ($urandom_range(0, 49) == 0);
         n_cpc  = {($urandom_range(0, 3) == 0) ? 24'hFFFFFF : {20'h0, 4'($urandom_range(0, 3))},
                   6'($urandom_range(0, 63)), 2'b00};
         step();
      end
      n_clr = 1'b0; n_full = 1'b0; n_rdy = 1'b1;
      s = n_strb;
      run_until(s + 3, "final_progress");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
